// File: rtl/des_perm_pipe.sv
// Registered DES IP/FP permutation with valid/ready handshake and 2-entry skid buffer.
// Optional macro DES_PERM_SWAP_EN adds swap_i (exchange 32-bit halves before FP).
module des_perm_pipe #(
    parameter int unsigned LANES = 1,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  mode_i,
`ifdef DES_PERM_SWAP_EN
    input  logic                  swap_i,
`endif
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [64*LANES-1:0]   data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [TAG_W-1:0]      tag_o,
    output logic [64*LANES-1:0]   data_o,
    output logic [CNT_W-1:0]      count_o
);

    localparam int unsigned W = 64 * LANES;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Source bit (DES numbering, 1 = MSB) for each output bit 1..64.
    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int unsigned FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    function automatic logic [63:0] permute(input logic [63:0] x, input logic fp);
        logic [63:0] y;
        logic [5:0]  src;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            src = 6'(64 - (fp ? FP_T[i] : IP_T[i]));
            y[6'(63 - i)] = x[src];
        end
        return y;
    endfunction

    logic [W-1:0] perm_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [63:0] lane;
        always_comb begin
            lane = data_i[64*k +: 64];
`ifdef DES_PERM_SWAP_EN
            if (swap_i && mode_i) begin
                lane = {lane[31:0], lane[63:32]};
            end
`endif
        end
        assign perm_d[64*k +: 64] = permute(lane, mode_i);
    end

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     main_q, main_d;
    logic [W-1:0]     skid_q, skid_d;
    logic [TAG_W-1:0] mtag_q, mtag_d;
    logic [TAG_W-1:0] stag_q, stag_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             init_q;
    logic             accept;
    logic             drain;

    // init_q keeps ready_o low through reset and for the first edge after release.
    assign valid_o = (state_q != ST_EMPTY);
    assign ready_o = init_q && (state_q != ST_TWO);
    assign accept  = valid_i && ready_o;
    assign drain   = valid_o && ready_i;
    assign data_o  = main_q;
    assign tag_o   = mtag_q;
    assign count_o = count_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        mtag_d  = mtag_q;
        stag_d  = stag_q;
        count_d = drain ? count_q + CNT_W'(1) : count_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = perm_d;
                    mtag_d  = tag_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = perm_d;
                    mtag_d = tag_i;
                end else if (accept) begin
                    skid_d  = perm_d;
                    stag_d  = tag_i;
                    state_d = ST_TWO;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    main_d  = skid_q;
                    mtag_d  = stag_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            mtag_q  <= '0;
            stag_q  <= '0;
            count_q <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            mtag_q  <= mtag_d;
            stag_q  <= stag_d;
            count_q <= count_d;
            init_q  <= 1'b1;
        end
    end

endmodule
